// File: rtl/reorder_buffer_pkg.sv
// Shared constants and per-entry control record for the reorder buffer.
package reorder_buffer_pkg;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned REG_BITS = 5;
  localparam int unsigned CNT_BITS = 4;

  typedef struct packed {
    logic                busy;
    logic                ready;
    logic                mispredict;
    logic [REG_BITS-1:0] dest;
  } rob_ctrl_t;

endpackage

// File: rtl/rob_entry_array.sv
// Reorder buffer storage: allocation write port, CDB write port, retire clear, head read.
module rob_entry_array
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = 31,
  parameter int unsigned ROB   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_all_i,
  input  logic                alloc_we_i,
  input  logic [ROB:0]        alloc_idx_i,
  input  logic [REG_BITS-1:0] alloc_dest_i,
  input  logic                cdb_we_i,
  input  logic [ROB:0]        cdb_idx_i,
  input  logic [WIDTH:0]      cdb_value_i,
  input  logic                cdb_mispredict_i,
  input  logic [WIDTH:0]      cdb_target_i,
  input  logic                retire_i,
  input  logic [ROB:0]        head_idx_i,
  output rob_ctrl_t           head_ctrl_o,
  output logic [WIDTH:0]      head_value_o,
  output logic [WIDTH:0]      head_target_o,
  output logic                cdb_busy_o
);

  rob_ctrl_t      ctrl_q   [DEPTH];
  logic [WIDTH:0] value_q  [DEPTH];
  logic [WIDTH:0] target_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ctrl_q[i] <= '0;
      end
    end else if (clear_all_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ctrl_q[i].busy  <= 1'b0;
        ctrl_q[i].ready <= 1'b0;
      end
    end else begin
      if (cdb_we_i) begin
        ctrl_q[cdb_idx_i].ready      <= 1'b1;
        ctrl_q[cdb_idx_i].mispredict <= cdb_mispredict_i;
      end
      if (retire_i) begin
        ctrl_q[head_idx_i].busy  <= 1'b0;
        ctrl_q[head_idx_i].ready <= 1'b0;
      end
      // The tail slot is never busy when allocation is allowed, so no port overlaps this one.
      if (alloc_we_i) begin
        ctrl_q[alloc_idx_i] <= '{busy: 1'b1, ready: 1'b0, mispredict: 1'b0, dest: alloc_dest_i};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cdb_we_i) begin
      value_q[cdb_idx_i]  <= cdb_value_i;
      target_q[cdb_idx_i] <= cdb_target_i;
    end
  end

  assign head_ctrl_o   = ctrl_q[head_idx_i];
  assign head_value_o  = value_q[head_idx_i];
  assign head_target_o = target_q[head_idx_i];
  assign cdb_busy_o    = ctrl_q[cdb_idx_i].busy;

endmodule

// File: rtl/reorder_buffer.sv
// Eight-entry in-order-retire reorder buffer with mispredict flush.
// Define ROB_CDB_BYPASS_EN to retire a head entry in the same cycle the CDB writes it.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = 31,
  parameter int unsigned ROB   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_valid,
  input  logic [REG_BITS-1:0] alloc_dest,
  output logic                alloc_ready,
  output logic [ROB:0]        alloc_tag,
  input  logic                cdb_valid,
  input  logic [ROB:0]        cdb_tag,
  input  logic [WIDTH:0]      cdb_result,
  input  logic                cdb_mispredict,
  input  logic [WIDTH:0]      cdb_target,
  output logic                commit_valid,
  output logic [REG_BITS-1:0] commit_dest,
  output logic [WIDTH:0]      commit_value,
  output logic                flush,
  output logic [WIDTH:0]      flush_pc
);

  localparam logic [ROB:0]          TagOne = 1;
  localparam logic [CNT_BITS-1:0]   CntOne = 1;
  localparam logic [CNT_BITS-1:0]   CntMax = CNT_BITS'(DEPTH);

  logic [ROB:0]          head_q, head_d, tail_q, tail_d;
  logic [CNT_BITS-1:0]   count_q, count_d;
  logic                  commit_valid_q, flush_q;
  logic [REG_BITS-1:0]   commit_dest_q;
  logic [WIDTH:0]        commit_value_q, flush_pc_q;

  rob_ctrl_t      head_ctrl;
  logic [WIDTH:0] head_value, head_target;
  logic           cdb_busy, bypass_hit, retire, retire_mp, flush_now, alloc_fire, cdb_fire;
  logic [WIDTH:0] retire_value, retire_target;

`ifdef ROB_CDB_BYPASS_EN
  assign bypass_hit = cdb_valid && (cdb_tag == head_q) && head_ctrl.busy;
`else
  assign bypass_hit = 1'b0;
`endif

  assign retire        = head_ctrl.busy && (head_ctrl.ready || bypass_hit);
  assign retire_mp     = bypass_hit ? cdb_mispredict : head_ctrl.mispredict;
  assign retire_value  = bypass_hit ? cdb_result : head_value;
  assign retire_target = bypass_hit ? cdb_target : head_target;
  assign flush_now     = retire && retire_mp;

  // Full is judged on the pre-commit count; a flush discards same-cycle alloc and CDB writes.
  assign alloc_ready = (count_q < CntMax);
  assign alloc_tag   = tail_q;
  assign alloc_fire  = alloc_valid && alloc_ready && !flush_now;
  assign cdb_fire    = cdb_valid && cdb_busy && !flush_now;

  rob_entry_array #(
    .WIDTH (WIDTH),
    .ROB   (ROB)
  ) u_entries (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear_all_i      (flush_now),
    .alloc_we_i       (alloc_fire),
    .alloc_idx_i      (tail_q),
    .alloc_dest_i     (alloc_dest),
    .cdb_we_i         (cdb_fire),
    .cdb_idx_i        (cdb_tag),
    .cdb_value_i      (cdb_result),
    .cdb_mispredict_i (cdb_mispredict),
    .cdb_target_i     (cdb_target),
    .retire_i         (retire),
    .head_idx_i       (head_q),
    .head_ctrl_o      (head_ctrl),
    .head_value_o     (head_value),
    .head_target_o    (head_target),
    .cdb_busy_o       (cdb_busy)
  );

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_now) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc_fire) tail_d = tail_q + TagOne;
      if (retire)     head_d = head_q + TagOne;
      unique case ({alloc_fire, retire})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_dest_q  <= '0;
      commit_value_q <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= retire;
      flush_q        <= flush_now;
      if (retire) begin
        commit_dest_q  <= head_ctrl.dest;
        commit_value_q <= retire_value;
      end
      if (flush_now) flush_pc_q <= retire_target;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_dest  = commit_dest_q;
  assign commit_value = commit_value_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer in its default build (no same-cycle CDB bypass).
module tb_reorder_buffer;

  localparam int W = 31;
  localparam int R = 2;

  logic         clk, rst_n;
  logic         alloc_valid, alloc_ready;
  logic [4:0]   alloc_dest;
  logic [R:0]   alloc_tag;
  logic         cdb_valid, cdb_mispredict;
  logic [R:0]   cdb_tag;
  logic [W:0]   cdb_result, cdb_target;
  logic         commit_valid, flush;
  logic [4:0]   commit_dest;
  logic [W:0]   commit_value, flush_pc;

  int checks = 0;
  int failures = 0;

  reorder_buffer #(
    .WIDTH (W),
    .ROB   (R)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alloc_valid    (alloc_valid),
    .alloc_dest     (alloc_dest),
    .alloc_ready    (alloc_ready),
    .alloc_tag      (alloc_tag),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_result     (cdb_result),
    .cdb_mispredict (cdb_mispredict),
    .cdb_target     (cdb_target),
    .commit_valid   (commit_valid),
    .commit_dest    (commit_dest),
    .commit_value   (commit_value),
    .flush          (flush),
    .flush_pc       (flush_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    alloc_valid    = 1'b0;
    alloc_dest     = '0;
    cdb_valid      = 1'b0;
    cdb_tag        = '0;
    cdb_result     = '0;
    cdb_mispredict = 1'b0;
    cdb_target     = '0;
  endtask

  task automatic do_reset;
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic cdb_drive(input logic [R:0] tag, input logic [W:0] val, input logic mp,
                           input logic [W:0] tgt);
    cdb_valid      = 1'b1;
    cdb_tag        = tag;
    cdb_result     = val;
    cdb_mispredict = mp;
    cdb_target     = tgt;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (alloc_ready !== 1'b1) begin failures++;
      $display("FAIL reset_alloc_ready: got %0b expected 1", alloc_ready); end
    checks++; if (alloc_tag !== 3'd0) begin failures++;
      $display("FAIL reset_alloc_tag: got %0d expected 0", alloc_tag); end
    checks++; if (commit_valid !== 1'b0) begin failures++;
      $display("FAIL reset_commit_valid: got %0b expected 0", commit_valid); end
    checks++; if (flush !== 1'b0) begin failures++;
      $display("FAIL reset_flush: got %0b expected 0", flush); end
    checks++; if (commit_dest !== 5'd0 || commit_value !== 32'd0 || flush_pc !== 32'd0) begin
      failures++;
      $display("FAIL reset_payload: got dest=%0d value=%h pc=%h expected all 0",
               commit_dest, commit_value, flush_pc); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 8; i++) begin
      checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'(i)) begin failures++;
        $display("FAIL fill_tag%0d: got ready=%0b tag=%0d expected ready=1 tag=%0d",
                 i, alloc_ready, alloc_tag, i); end
      alloc_valid = 1'b1;
      alloc_dest  = 5'(i);
      tick();
    end
    alloc_valid = 1'b0;
    checks++; if (alloc_ready !== 1'b0 || alloc_tag !== 3'd0) begin failures++;
      $display("FAIL fill_full: got ready=%0b tag=%0d expected ready=0 tag=0",
               alloc_ready, alloc_tag); end
    alloc_valid = 1'b1;
    alloc_dest  = 5'd31;
    tick();
    alloc_valid = 1'b0;
    checks++; if (alloc_ready !== 1'b0 || alloc_tag !== 3'd0) begin failures++;
      $display("FAIL ninth_alloc: got ready=%0b tag=%0d expected ready=0 tag=0",
               alloc_ready, alloc_tag); end
    checks++; if (commit_valid !== 1'b0) begin failures++;
      $display("FAIL fill_no_commit: got %0b expected 0", commit_valid); end
  endtask

  // Buffer starts full with dest == tag for tags 0..7.
  task automatic test_in_order_full;
    cdb_drive(3'd2, 32'h22, 1'b0, 32'h0);
    tick();
    checks++; if (commit_valid !== 1'b0) begin failures++;
      $display("FAIL order_early_commit: got %0b expected 0", commit_valid); end
    cdb_drive(3'd0, 32'h10, 1'b0, 32'h0);
    tick();
    checks++; if (commit_valid !== 1'b0) begin failures++;
      $display("FAIL order_latency: got %0b expected 0", commit_valid); end
    cdb_drive(3'd1, 32'h11, 1'b0, 32'h0);
    alloc_valid = 1'b1;
    alloc_dest  = 5'd9;
    checks++; if (alloc_ready !== 1'b0) begin failures++;
      $display("FAIL full_refuse: got ready=%0b expected 0", alloc_ready); end
    tick();
    cdb_valid = 1'b0;
    checks++; if (commit_valid !== 1'b1 || commit_dest !== 5'd0 || commit_value !== 32'h10) begin
      failures++;
      $display("FAIL commit0: got v=%0b dest=%0d val=%h expected v=1 dest=0 val=10",
               commit_valid, commit_dest, commit_value); end
    checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin failures++;
      $display("FAIL full_accept_next: got ready=%0b tag=%0d expected ready=1 tag=0",
               alloc_ready, alloc_tag); end
    tick();
    alloc_valid = 1'b0;
    checks++; if (commit_valid !== 1'b1 || commit_dest !== 5'd1 || commit_value !== 32'h11) begin
      failures++;
      $display("FAIL commit1: got v=%0b dest=%0d val=%h expected v=1 dest=1 val=11",
               commit_valid, commit_dest, commit_value); end
    checks++; if (alloc_tag !== 3'd1) begin failures++;
      $display("FAIL realloc_tag: got %0d expected 1", alloc_tag); end
    tick();
    checks++; if (commit_valid !== 1'b1 || commit_dest !== 5'd2 || commit_value !== 32'h22) begin
      failures++;
      $display("FAIL commit2: got v=%0b dest=%0d val=%h expected v=1 dest=2 val=22",
               commit_valid, commit_dest, commit_value); end
    tick();
    checks++; if (commit_valid !== 1'b0) begin failures++;
      $display("FAIL commit_stop: got %0b expected 0", commit_valid); end
    // Six entries remain; two more allocations must fill the buffer exactly.
    alloc_valid = 1'b1;
    alloc_dest  = 5'd20;
    tick();
    checks++; if (alloc_ready !== 1'b1) begin failures++;
      $display("FAIL count_seven: got ready=%0b expected 1", alloc_ready); end
    tick();
    alloc_valid = 1'b0;
    checks++; if (alloc_ready !== 1'b0 || alloc_tag !== 3'd3) begin failures++;
      $display("FAIL count_full_again: got ready=%0b tag=%0d expected ready=0 tag=3",
               alloc_ready, alloc_tag); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 5'(i + 4);
      tick();
    end
    alloc_valid = 1'b0;
    cdb_drive(3'd0, 32'h70, 1'b0, 32'h0);
    tick();
    cdb_drive(3'd1, 32'h71, 1'b0, 32'h0);
    tick();
    cdb_valid = 1'b0;
    checks++; if (commit_valid !== 1'b1 || commit_dest !== 5'd4) begin failures++;
      $display("FAIL mid_pre_commit: got v=%0b dest=%0d expected v=1 dest=4",
               commit_valid, commit_dest); end
    rst_n = 1'b0;
    #1;
    checks++; if (commit_valid !== 1'b0 || commit_dest !== 5'd0 || commit_value !== 32'd0) begin
      failures++;
      $display("FAIL mid_async_clear: got v=%0b dest=%0d val=%h expected 0",
               commit_valid, commit_dest, commit_value); end
    tick();
    rst_n = 1'b1;
    checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0 || commit_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_release: got ready=%0b tag=%0d v=%0b expected ready=1 tag=0 v=0",
               alloc_ready, alloc_tag, commit_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (commit_valid !== 1'b0) begin failures++;
        $display("FAIL mid_stale_commit%0d: got %0b expected 0", i, commit_valid); end
    end
  endtask

  task automatic test_cdb_unallocated;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 5'(i + 1);
      tick();
    end
    alloc_valid = 1'b0;
    cdb_drive(3'd5, 32'h55, 1'b1, 32'h999);
    tick();
    idle();
    tick();
    checks++; if (commit_valid !== 1'b0 || flush !== 1'b0) begin failures++;
      $display("FAIL unalloc_effect: got v=%0b flush=%0b expected 0 0", commit_valid, flush); end
    checks++; if (alloc_tag !== 3'd2 || alloc_ready !== 1'b1) begin failures++;
      $display("FAIL unalloc_ptrs: got tag=%0d ready=%0b expected tag=2 ready=1",
               alloc_tag, alloc_ready); end
    for (int i = 2; i < 6; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 5'(i + 1);
      tick();
    end
    alloc_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cdb_drive(3'(i), 32'h50 + 32'(i), 1'b0, 32'h0);
      tick();
      if (i >= 1) begin
        checks++;
        if (commit_valid !== 1'b1 || commit_dest !== 5'(i) || commit_value !== 32'h50 + 32'(i - 1))
        begin
          failures++;
          $display("FAIL unalloc_drain%0d: got v=%0b dest=%0d val=%h expected v=1 dest=%0d val=%h",
                   i, commit_valid, commit_dest, commit_value, i, 32'h50 + 32'(i - 1));
        end
      end
    end
    idle();
    tick();
    checks++; if (commit_valid !== 1'b1 || commit_dest !== 5'd5 || commit_value !== 32'h54) begin
      failures++;
      $display("FAIL unalloc_drain5: got v=%0b dest=%0d val=%h expected v=1 dest=5 val=54",
               commit_valid, commit_dest, commit_value); end
    tick();
    checks++; if (commit_valid !== 1'b0 || flush !== 1'b0) begin failures++;
      $display("FAIL tag5_not_ready: got v=%0b flush=%0b expected 0 0", commit_valid, flush); end
  endtask

  task automatic test_mispredict;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1;
      alloc_dest  = 5'(i + 10);
      tick();
    end
    alloc_valid = 1'b0;
    checks++; if (alloc_tag !== 3'd4) begin failures++;
      $display("FAIL mp_alloc_tag: got %0d expected 4", alloc_tag); end
    cdb_drive(3'd0, 32'hA0, 1'b0, 32'h0);
    tick();
    cdb_drive(3'd1, 32'hB1, 1'b1, 32'h0000_0400);
    tick();
    checks++; if (commit_valid !== 1'b1 || commit_dest !== 5'd10 || commit_value !== 32'hA0 ||
                  flush !== 1'b0) begin
      failures++;
      $display("FAIL mp_commit0: got v=%0b dest=%0d val=%h flush=%0b expected 1 10 a0 0",
               commit_valid, commit_dest, commit_value, flush); end
    cdb_drive(3'd2, 32'hC2, 1'b0, 32'h0);
    alloc_valid = 1'b1;
    alloc_dest  = 5'd14;
    tick();
    idle();
    checks++; if (commit_valid !== 1'b1 || commit_dest !== 5'd11 || commit_value !== 32'hB1) begin
      failures++;
      $display("FAIL mp_commit1: got v=%0b dest=%0d val=%h expected v=1 dest=11 val=b1",
               commit_valid, commit_dest, commit_value); end
    checks++; if (flush !== 1'b1 || flush_pc !== 32'h0000_0400) begin failures++;
      $display("FAIL mp_flush: got flush=%0b pc=%h expected flush=1 pc=00000400",
               flush, flush_pc); end
    checks++; if (alloc_tag !== 3'd0 || alloc_ready !== 1'b1) begin failures++;
      $display("FAIL mp_ptrs: got tag=%0d ready=%0b expected tag=0 ready=1",
               alloc_tag, alloc_ready); end
    tick();
    checks++; if (flush !== 1'b0 || commit_valid !== 1'b0 || alloc_tag !== 3'd0) begin
      failures++;
      $display("FAIL mp_after: got flush=%0b v=%0b tag=%0d expected 0 0 0",
               flush, commit_valid, alloc_tag); end
    tick();
    checks++; if (commit_valid !== 1'b0) begin failures++;
      $display("FAIL mp_no_residue: got %0b expected 0", commit_valid); end
    // Count must be zero: exactly eight allocations fit.
    for (int i = 0; i < 8; i++) begin
      checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'(i)) begin failures++;
        $display("FAIL mp_refill%0d: got ready=%0b tag=%0d expected ready=1 tag=%0d",
                 i, alloc_ready, alloc_tag, i); end
      alloc_valid = 1'b1;
      alloc_dest  = 5'(i);
      tick();
    end
    alloc_valid = 1'b0;
    checks++; if (alloc_ready !== 1'b0) begin failures++;
      $display("FAIL mp_refill_full: got ready=%0b expected 0", alloc_ready); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_fill();
    test_in_order_full();
    test_reset_mid();
    test_cdb_unallocated();
    test_mispredict();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
